// File: rtl/wb_register_bank.sv
// Write-back stage mux, 2**NB_REG-entry GPR file with two bypassed read ports,
// and a ready/valid register dump engine for the debug unit.
module wb_register_bank #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_WB_reg_write,
  input  logic               i_WB_mem_to_reg,
  input  logic [NB_DATA-1:0] i_WB_mem_data,
  input  logic [NB_DATA-1:0] i_WB_alu_result,
  input  logic [NB_REG-1:0]  i_WB_selected_reg,
  input  logic               i_WB_r31_ctrl,
  input  logic [NB_PC-1:0]   i_WB_pc,
  input  logic [NB_REG-1:0]  i_ID_rs_addr,
  input  logic [NB_REG-1:0]  i_ID_rt_addr,
  output logic [NB_DATA-1:0] o_ID_rs_data,
  output logic [NB_DATA-1:0] o_ID_rt_data,
  output logic [NB_DATA-1:0] o_WB_wr_data,
  input  logic               i_dbg_start,
  input  logic               i_dbg_ready,
  output logic               o_dbg_valid,
  output logic [NB_REG-1:0]  o_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_dbg_done
);

  // state   | meaning
  // IDLE    | no dump in progress, waiting for i_dbg_start
  // DUMP    | presenting beat idx, advancing on valid & ready
  // DONE    | one-cycle done pulse after the last beat is accepted
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int              N_REGS   = 2 ** NB_REG;
  localparam logic [NB_REG-1:0] LAST_IDX = '1;

  logic [NB_DATA-1:0] gpr [N_REGS];
  logic [NB_DATA-1:0] wr_data;
  logic               wr_en;

  state_t             state, state_next;
  logic [NB_REG-1:0]  idx;
  logic [NB_DATA-1:0] dbg_data;
  logic               beat_accept;
  logic               load_beat;
  logic [NB_REG-1:0]  beat_addr;
  logic [NB_DATA-1:0] beat_data;

  always_comb begin
    wr_data = i_WB_alu_result;
    if (i_WB_r31_ctrl)
      wr_data = NB_DATA'(i_WB_pc);
    else if (i_WB_mem_to_reg)
      wr_data = i_WB_mem_data;
  end

  assign o_WB_wr_data = wr_data;
  assign wr_en        = i_WB_reg_write && (i_WB_selected_reg != '0);

  // GPR[0] is never a write target, so it stays at its reset value of zero
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_REGS; i++)
        gpr[i] <= '0;
    end else if (wr_en) begin
      gpr[i_WB_selected_reg] <= wr_data;
    end
  end

  assign o_ID_rs_data = (wr_en && (i_ID_rs_addr == i_WB_selected_reg)) ? wr_data : gpr[i_ID_rs_addr];
  assign o_ID_rt_data = (wr_en && (i_ID_rt_addr == i_WB_selected_reg)) ? wr_data : gpr[i_ID_rt_addr];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    beat_accept = 1'b0;
    load_beat   = 1'b0;
    o_dbg_valid = 1'b0;
    o_dbg_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_dbg_start) begin
          state_next = ST_DUMP;
          load_beat  = 1'b1;
        end
      end
      ST_DUMP: begin
        o_dbg_valid = 1'b1;
        beat_accept = i_dbg_ready;
        if (beat_accept) begin
          if (idx == LAST_IDX)
            state_next = ST_DONE;
          else
            load_beat = 1'b1;
        end
      end
      ST_DONE: begin
        o_dbg_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The next beat is captured at the edge it becomes visible, so it sees any
  // write committing on that same edge; a presented beat then holds.
  assign beat_addr = (state == ST_IDLE) ? '0 : idx + NB_REG'(1);
  assign beat_data = (wr_en && (beat_addr == i_WB_selected_reg)) ? wr_data : gpr[beat_addr];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx      <= '0;
      dbg_data <= '0;
    end else if (load_beat) begin
      idx      <= beat_addr;
      dbg_data <= beat_data;
    end
  end

  assign o_dbg_addr = idx;
  assign o_dbg_data = dbg_data;

endmodule

// File: tb/tb_wb_register_bank.sv
// Randomized and directed checks of wb_register_bank against an array model
// of the register file and a beat-by-beat model of the debug dump.
module tb_wb_register_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write, mem_to_reg, r31_ctrl;
  logic [31:0] mem_data, alu_result, pc;
  logic [4:0]  sel, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_wr_data;
  logic        dbg_start, dbg_ready, dbg_valid, dbg_done;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [31:0] ref_gpr [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_register_bank #(.NB_DATA(32), .NB_REG(5), .NB_PC(32)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_WB_reg_write(reg_write), .i_WB_mem_to_reg(mem_to_reg),
    .i_WB_mem_data(mem_data), .i_WB_alu_result(alu_result),
    .i_WB_selected_reg(sel), .i_WB_r31_ctrl(r31_ctrl), .i_WB_pc(pc),
    .i_ID_rs_addr(rs_addr), .i_ID_rt_addr(rt_addr),
    .o_ID_rs_data(rs_data), .o_ID_rt_data(rt_data), .o_WB_wr_data(wb_wr_data),
    .i_dbg_start(dbg_start), .i_dbg_ready(dbg_ready),
    .o_dbg_valid(dbg_valid), .o_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_data), .o_dbg_done(dbg_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wr();
    if (r31_ctrl) return pc;
    if (mem_to_reg) return mem_data;
    return alu_result;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (reg_write && sel != 0 && a == sel) return m_wr();
    return ref_gpr[a];
  endfunction

  task automatic set_wb(input logic we, input logic m2r, input logic r31,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] p, input logic [4:0] dst);
    reg_write = we; mem_to_reg = m2r; r31_ctrl = r31;
    alu_result = alu; mem_data = mem; pc = p; sel = dst;
  endtask

  task automatic check_ports(input string tag);
    chk({tag, "_rs"}, rs_data, m_read(rs_addr));
    chk({tag, "_rt"}, rt_data, m_read(rt_addr));
    chk({tag, "_wr"}, wb_wr_data, m_wr());
  endtask

  task automatic tick();
    @(posedge clk);
    if (reg_write && sel != 0) ref_gpr[sel] = m_wr();
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_gpr[i] = '0;
  endtask

  logic [31:0] exp_data;
  int          exp_idx, beats, holds;
  logic        presented, accept, done_seen;

  initial begin
    clear_model();
    rst_n = 1'b0;
    set_wb(0, 0, 0, 0, 0, 0, 0);
    rs_addr = 5'd5; rt_addr = 5'd7;
    dbg_start = 1'b0; dbg_ready = 1'b0;
    #2;
    chk("reset_rs", rs_data, 32'h0);
    chk("reset_valid", {31'b0, dbg_valid}, 32'h0);
    chk("reset_done", {31'b0, dbg_done}, 32'h0);
    chk("reset_dbg_addr", {27'b0, dbg_addr}, 32'h0);
    chk("reset_dbg_data", dbg_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // write r5 from the ALU: visible via bypass, then from the array
    set_wb(1, 0, 0, 32'h1234, 32'h5555, 32'h0, 5'd5);
    rs_addr = 5'd5; rt_addr = 5'd0;
    #1;
    chk("r5_bypass", rs_data, 32'h1234);
    check_ports("r5_pre");
    tick();
    set_wb(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r5_after", rs_data, 32'h1234);

    set_wb(1, 1, 0, 32'h1111, 32'hDEADBEEF, 32'h0, 5'd7);
    tick();
    set_wb(0, 0, 0, 0, 0, 0, 0);
    rt_addr = 5'd7;
    #1;
    chk("r7_load", rt_data, 32'hDEADBEEF);

    set_wb(1, 1, 1, 32'h2222, 32'h3333, 32'h40, 5'd31);
    #1;
    chk("link_wr_data", wb_wr_data, 32'h40);
    tick();
    set_wb(0, 0, 0, 0, 0, 0, 0);
    rs_addr = 5'd31;
    #1;
    chk("r31_link", rs_data, 32'h40);

    set_wb(1, 0, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0);
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    chk("r0_no_bypass_rs", rs_data, 32'h0);
    chk("r0_no_bypass_rt", rt_data, 32'h0);
    tick();
    #1;
    chk("r0_after", rs_data, 32'h0);

    for (int n = 0; n < 300; n++) begin
      set_wb($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
             $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
      rs_addr = ($urandom_range(0, 3) == 0) ? sel : 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? sel : 5'($urandom_range(0, 31));
      #1;
      check_ports("rand");
      tick();
    end

    // dump with r3=0x33, ready toggling, writes (never to r3) continuing
    set_wb(1, 0, 0, 32'h33, 32'h0, 32'h0, 5'd3);
    tick();
    set_wb(0, 0, 0, 0, 0, 0, 0);
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    exp_idx = 0; beats = 0; holds = 0; presented = 1'b0; done_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      dbg_ready = (cyc % 2 == 0);
      dbg_start = (cyc == 5);
      set_wb($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, $urandom, $urandom, 32'h0,
             5'($urandom_range(4, 31)));
      rs_addr = 5'($urandom_range(0, 31)); rt_addr = sel;
      accept = 1'b0;
      #1;
      check_ports("dump");
      if (cyc == 0) chk("first_beat_latency", {31'b0, dbg_valid}, 32'h1);
      if (dbg_valid) begin
        if (!presented) begin
          exp_data = ref_gpr[exp_idx];
          presented = 1'b1;
        end else begin
          holds++;
        end
        chk("beat_addr", {27'b0, dbg_addr}, exp_idx);
        chk("beat_data", dbg_data, exp_data);
        chk("done_during_dump", {31'b0, dbg_done}, 32'h0);
        if (exp_idx == 3) chk("beat3_data", dbg_data, 32'h33);
        accept = dbg_ready;
      end else begin
        chk("dump_done_pulse", {31'b0, dbg_done}, 32'h1);
        chk("dump_beat_count", beats, 32);
        done_seen = 1'b1;
      end
      tick();
      if (accept) begin
        exp_idx++;
        beats++;
        presented = 1'b0;
      end
    end
    chk("dump_finished", {31'b0, done_seen}, 32'h1);
    chk("dump_had_holds", {31'b0, (holds > 0)}, 32'h1);
    set_wb(0, 0, 0, 0, 0, 0, 0);
    dbg_ready = 1'b1;
    #1;
    chk("done_single_pulse", {31'b0, dbg_done}, 32'h0);
    chk("idle_valid", {31'b0, dbg_valid}, 32'h0);

    // reset in the middle of a dump: aborted, no done pulse afterwards
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rs_addr = 5'd31; rt_addr = 5'd7;
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("midreset_valid", {31'b0, dbg_valid}, 32'h0);
    chk("midreset_done", {31'b0, dbg_done}, 32'h0);
    chk("midreset_rs", rs_data, 32'h0);
    chk("midreset_rt", rt_data, 32'h0);
    chk("midreset_dbg_addr", {27'b0, dbg_addr}, 32'h0);
    chk("midreset_dbg_data", dbg_data, 32'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("post_reset_no_done", {31'b0, dbg_done}, 32'h0);
      chk("post_reset_no_valid", {31'b0, dbg_valid}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
